coherence_bus_arbiter: RTL and testbench

- Shared snooping-bus controller for NUM_CPUS per-processor MSI cache controllers.
- Grants the bus round-robin to one requester at a time and broadcasts its coherence message and address to all caches.
- Collects a snoop acknowledge from every other cache and sequences any memory write-back.
- Signals completion back to the winning requester.

---
 rtl/coherence_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter for NUM_CPUS MSI cache controllers: round-robin grant, broadcast, snoop-ack collection, write-back sequencing.
// Optional BUS_STATS_EN adds txn_count/wb_count transaction counters.
module coherence_bus_arbiter #(
  parameter int unsigned NUM_CPUS = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_CPUS-1:0]        req,
  input  logic [3*NUM_CPUS-1:0]      req_msg,
  input  logic [ADDR_W*NUM_CPUS-1:0] req_addr,
  input  logic [NUM_CPUS-1:0]        snoop_ack,
  input  logic [NUM_CPUS-1:0]        snoop_wb,
  input  logic                       mem_wb_done,
  output logic [NUM_CPUS-1:0]        grant,
  output logic [NUM_CPUS-1:0]        done,
  output logic                       bus_valid,
  output logic [2:0]                 bus_msg,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [2:0]                 bus_src,
  output logic                       mem_wb_req,
  output logic [2:0]                 arb_state
`ifdef BUS_STATS_EN
  ,
  output logic [7:0]                 txn_count,
  output logic [7:0]                 wb_count
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BCAST = 3'd1,
    SNOOP = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CPUS-1:0] grant_q, grant_d;
  logic [NUM_CPUS-1:0] ack_q, ack_d;
  logic                wb_q, wb_d;
  logic [2:0]          msg_q, msg_d;
  logic [2:0]          src_q, src_d;
  logic [2:0]          last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [NUM_CPUS-1:0] valid, win_oh, src_oh, ack_all;
  logic                found, wb_now;
  logic [2:0]          win_idx, win_msg;
  logic [ADDR_W-1:0]   win_addr;

  // Round-robin: rank 0 is the CPU right after last_q; the lowest-ranked valid requester wins.
  always_comb begin : arb
    int unsigned rank;
    int unsigned best;
    valid    = '0;
    win_oh   = '0;
    found    = 1'b0;
    win_idx  = '0;
    win_msg  = '0;
    win_addr = '0;
    best     = NUM_CPUS;
    rank     = 0;
    for (int unsigned j = 0; j < NUM_CPUS; j++) begin
      valid[j] = req[j] && (req_msg[3*j +: 3] != 3'b000) && (req_msg[3*j +: 3] <= 3'b101);
      rank     = (j + 2*NUM_CPUS - 32'(last_q) - 1) % NUM_CPUS;
      if (valid[j] && (rank < best)) begin
        best     = rank;
        found    = 1'b1;
        win_idx  = 3'(j);
        win_msg  = req_msg[3*j +: 3];
        win_addr = req_addr[ADDR_W*j +: ADDR_W];
      end
    end
    for (int unsigned j = 0; j < NUM_CPUS; j++) begin
      win_oh[j] = found && (win_idx == 3'(j));
    end
  end

  always_comb begin
    src_oh = '0;
    for (int unsigned j = 0; j < NUM_CPUS; j++) begin
      src_oh[j] = (src_q == 3'(j));
    end
    ack_all = ack_q | (snoop_ack & ~src_oh);
    wb_now  = wb_q | (|(snoop_wb & snoop_ack & ~src_oh));
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = ack_q;
    wb_d       = wb_q;
    msg_d      = msg_q;
    src_d      = src_q;
    last_d     = last_q;
    addr_d     = addr_q;
    done       = '0;
    bus_valid  = 1'b0;
    mem_wb_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win_oh;
          msg_d   = win_msg;
          addr_d  = win_addr;
          src_d   = win_idx;
          state_d = BCAST;
        end
      end
      BCAST: begin
        bus_valid = 1'b1;
        if ((msg_q == 3'b100) || (msg_q == 3'b101)) begin
          state_d = WB;
        end else begin
          ack_d   = '0;
          wb_d    = 1'b0;
          state_d = SNOOP;
        end
      end
      SNOOP: begin
        ack_d = ack_all;
        wb_d  = wb_now;
        // The owner's bit is forced set so a single-CPU system exits after one cycle.
        if ((ack_all | src_oh) == '1) begin
          state_d = wb_now ? WB : DONE;
        end
      end
      WB: begin
        mem_wb_req = 1'b1;
        if (mem_wb_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = src_oh;
        last_d  = src_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      wb_q    <= 1'b0;
      msg_q   <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      last_q  <= 3'(NUM_CPUS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      wb_q    <= wb_d;
      msg_q   <= msg_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign bus_msg   = msg_q;
  assign bus_addr  = addr_q;
  assign bus_src   = src_q;
  assign arb_state = state_q;

`ifdef BUS_STATS_EN
  logic [7:0] txn_count_q, txn_count_d;
  logic [7:0] wb_count_q, wb_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    wb_count_d  = wb_count_q;
    if (state_q == DONE) begin
      txn_count_d = txn_count_q + 8'd1;
    end
    if ((state_q == WB) && mem_wb_done) begin
      wb_count_d = wb_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      txn_count_q <= '0;
      wb_count_q  <= '0;
    end else begin
      txn_count_q <= txn_count_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign txn_count = txn_count_q;
  assign wb_count  = wb_count_q;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Self-checking bench for coherence_bus_arbiter: directed literal scenarios plus randomized traffic against a transaction-level model.
module tb_coherence_bus_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 4;

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    req, snoop_ack, snoop_wb;
  logic [3*N-1:0]  req_msg;
  logic [AW*N-1:0] req_addr;
  logic            mem_wb_done;
  logic [N-1:0]    grant, done;
  logic            bus_valid, mem_wb_req;
  logic [2:0]      bus_msg, bus_src, arb_state;
  logic [AW-1:0]   bus_addr;
`ifdef BUS_STATS_EN
  logic [7:0]      txn_count, wb_count;
`endif

  coherence_bus_arbiter #(.NUM_CPUS(N), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_msg(req_msg), .req_addr(req_addr),
    .snoop_ack(snoop_ack), .snoop_wb(snoop_wb), .mem_wb_done(mem_wb_done),
    .grant(grant), .done(done), .bus_valid(bus_valid), .bus_msg(bus_msg),
    .bus_addr(bus_addr), .bus_src(bus_src), .mem_wb_req(mem_wb_req), .arb_state(arb_state)
`ifdef BUS_STATS_EN
    , .txn_count(txn_count), .wb_count(wb_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 broadcast, 2 snooping, 3 memory write-back, 4 completing.
  int            m_phase = 0;
  int            m_owner = 0;
  int            m_last  = N - 1;
  logic [2:0]    m_msg   = '0;
  logic [AW-1:0] m_addr  = '0;
  bit   [N-1:0]  m_acked = '0;
  bit            m_wb    = 1'b0;
  int            m_txn   = 0;
  int            m_wbc   = 0;
  int            n_done  = 0;

  task automatic model_step();
    bit         picked;
    bit         all;
    int         c;
    logic [2:0] mm;
    if (!resetn) begin
      m_phase = 0; m_owner = 0; m_last = N - 1; m_msg = '0; m_addr = '0;
      m_acked = '0; m_wb = 1'b0; m_txn = 0; m_wbc = 0;
    end else begin
      case (m_phase)
        0: begin
          picked = 1'b0;
          for (int k = 1; k <= N; k++) begin
            c  = (m_last + k) % N;
            mm = req_msg[3*c +: 3];
            if (!picked && req[c] && mm >= 3'd1 && mm <= 3'd5) begin
              picked = 1'b1; m_owner = c; m_msg = mm; m_addr = req_addr[AW*c +: AW]; m_phase = 1;
            end
          end
        end
        1: begin
          if (m_msg == 3'd4 || m_msg == 3'd5) m_phase = 3;
          else begin m_acked = '0; m_wb = 1'b0; m_phase = 2; end
        end
        2: begin
          all = 1'b1;
          for (int j = 0; j < N; j++) begin
            if (j != m_owner) begin
              if (snoop_ack[j]) m_acked[j] = 1'b1;
              if (snoop_ack[j] && snoop_wb[j]) m_wb = 1'b1;
              if (!m_acked[j]) all = 1'b0;
            end
          end
          if (all) m_phase = m_wb ? 3 : 4;
        end
        3: if (mem_wb_done) begin m_phase = 4; m_wbc++; end
        default: begin m_txn++; n_done++; m_last = m_owner; m_phase = 0; end
      endcase
    end
  endtask

  always @(negedge clock) begin
    check("grant", 32'(grant), (m_phase != 0) ? 32'(1) << m_owner : 32'd0);
    check("done", 32'(done), (m_phase == 4) ? 32'(1) << m_owner : 32'd0);
    check("bus_valid", 32'(bus_valid), 32'(m_phase == 1));
    check("mem_wb_req", 32'(mem_wb_req), 32'(m_phase == 3));
    check("bus_msg", 32'(bus_msg), 32'(m_msg));
    check("bus_addr", 32'(bus_addr), 32'(m_addr));
    check("bus_src", 32'(bus_src), 32'(m_owner));
    check("arb_state", 32'(arb_state), 32'(m_phase));
`ifdef BUS_STATS_EN
    check("txn_count", 32'(txn_count), 32'(m_txn % 256));
    check("wb_count", 32'(wb_count), 32'(m_wbc % 256));
`endif
    model_step();
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input int cpu, input logic [2:0] msg, input logic [AW-1:0] addr);
    req_msg[3*cpu +: 3]   = msg;
    req_addr[AW*cpu +: AW] = addr;
  endtask

`ifdef BUS_STATS_EN
  task automatic run_txn(input int cpu, input logic [2:0] msg);
    bit fin;
    set_cpu(cpu, msg, 4'h1);
    req = 4'(1 << cpu);
    snoop_ack = '1; snoop_wb = '0; mem_wb_done = 1'b1;
    tick();
    req = '0;
    fin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!fin) begin
        tick();
        if (arb_state == 3'd0) fin = 1'b1;
      end
    end
    check("stats_txn_timeout", 32'(fin), 32'd1);
    mem_wb_done = 1'b0;
  endtask
`endif

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    resetn = 1'b0; req = '0; req_msg = '0; req_addr = '0;
    snoop_ack = '0; snoop_wb = '0; mem_wb_done = 1'b0;
    repeat (2) tick();
    check("rst_state", 32'(arb_state), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_bus_src", 32'(bus_src), 32'd0);

    // Single read miss from CPU0
    resetn = 1'b1; req = 4'b0001; set_cpu(0, 3'b001, 4'd5); snoop_ack = 4'b1110;
    tick();
    check("t1_bus_valid", 32'(bus_valid), 32'd1);
    check("t1_bus_msg", 32'(bus_msg), 32'd1);
    check("t1_bus_addr", 32'(bus_addr), 32'd5);
    check("t1_bus_src", 32'(bus_src), 32'd0);
    check("t1_grant", 32'(grant), 32'b0001);
    req = '0;
    tick();
    check("t1_snoop", 32'(arb_state), 32'd2);
    tick();
    check("t1_done", 32'(done), 32'b0001);
    check("t1_no_wb", 32'(mem_wb_req), 32'd0);
    tick();
    check("t1_idle", 32'(arb_state), 32'd0);
    check("t1_msg_hold", 32'(bus_msg), 32'd1);

    // Round-robin rotation with all CPUs requesting
    resetn = 1'b0; tick(); resetn = 1'b1;
    req = 4'b1111; snoop_ack = 4'b1111;
    for (int c = 0; c < 4; c++) set_cpu(c, 3'b011, 4'(c + 8));
    for (int t = 0; t < 5; t++) begin
      tick();
      check("t2_src", 32'(bus_src), 32'(exp_order[t]));
      tick(); tick();
      check("t2_done", 32'(done), 32'(1) << exp_order[t]);
      if (t == 4) req = '0;
      tick();
    end

    // Invalidate from CPU2 with staggered acks and a write-back
    req = 4'b0100; set_cpu(2, 3'b010, 4'd3); snoop_ack = '0; snoop_wb = '0;
    tick();
    check("t3_src", 32'(bus_src), 32'd2);
    req = '0;
    tick();
    snoop_ack = 4'b0010; snoop_wb = 4'b0010;
    tick();
    check("t3_wait1", 32'(arb_state), 32'd2);
    snoop_ack = '0; snoop_wb = '0;
    tick();
    check("t3_wait2", 32'(arb_state), 32'd2);
    snoop_ack = 4'b1001;
    tick();
    check("t3_wb", 32'(arb_state), 32'd3);
    check("t3_wb_req", 32'(mem_wb_req), 32'd1);
    snoop_ack = '0;
    tick();
    check("t3_wb_hold", 32'(mem_wb_req), 32'd1);
    mem_wb_done = 1'b1;
    tick();
    check("t3_done", 32'(done), 32'b0100);
    mem_wb_done = 1'b0;
    tick();

    // Write Back Cache Block from CPU3 bypasses snooping
    req = 4'b1000; set_cpu(3, 3'b101, 4'hA); snoop_ack = 4'b1111;
    tick();
    check("t4_msg", 32'(bus_msg), 32'd5);
    req = '0;
    tick();
    check("t4_wb", 32'(arb_state), 32'd3);
    tick();
    check("t4_wb_hold", 32'(arb_state), 32'd3);
    mem_wb_done = 1'b1;
    tick();
    check("t4_done", 32'(done), 32'b1000);
    mem_wb_done = 1'b0; snoop_ack = '0;
    tick();

    // Empty and undefined messages are never granted
    req = 4'b0010; set_cpu(1, 3'b000, 4'd1);
    repeat (3) tick();
    check("t5_empty", 32'(arb_state), 32'd0);
    set_cpu(1, 3'b110, 4'd1);
    tick();
    check("t5_undef", 32'(grant), 32'd0);

    // Reset during SNOOP restores CPU0 priority
    req = 4'b0001; set_cpu(0, 3'b001, 4'd2); snoop_ack = 4'b1111;
    tick(); req = '0; tick(); tick(); tick();
    req = 4'b0010; set_cpu(1, 3'b001, 4'd4); snoop_ack = '0;
    tick();
    check("t6_src1", 32'(bus_src), 32'd1);
    req = '0;
    tick();
    check("t6_snoop", 32'(arb_state), 32'd2);
    resetn = 1'b0;
    tick();
    check("t6_rst_state", 32'(arb_state), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    resetn = 1'b1; req = 4'b1111; snoop_ack = 4'b1111;
    for (int c = 0; c < 4; c++) set_cpu(c, 3'b001, 4'(c));
    tick();
    check("t6_cpu0_first", 32'(bus_src), 32'd0);
    req = '0;
    repeat (3) tick();

`ifdef BUS_STATS_EN
    resetn = 1'b0; tick(); resetn = 1'b1;
    run_txn(0, 3'b001);
    run_txn(1, 3'b011);
    run_txn(2, 3'b010);
    run_txn(3, 3'b100);
    check("stats_txn", 32'(txn_count), 32'd4);
    check("stats_wb", 32'(wb_count), 32'd1);
`endif

    // Randomized traffic, including mid-transaction input churn and occasional resets
    n_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      resetn      = ($urandom_range(0, 199) != 0);
      req         = N'($urandom);
      req_msg     = (3*N)'($urandom);
      req_addr    = (AW*N)'($urandom);
      snoop_ack   = N'($urandom);
      snoop_wb    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      mem_wb_done = ($urandom_range(0, 2) == 0);
      tick();
    end
    check("rand_activity", 32'(n_done > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
